addsub_seq: RTL and testbench

Parametrised multi-cycle adder/subtractor that processes a WIDTH-bit operation CHUNK bits per clock through a ripple full-adder slice. It generalises the lab's complement-and-add subtract path to arbitrary width. It adds an add/subtract mode select, a start/busy/done handshake and registered status flags. It sits between operand registers and the result datapath, wherever a narrow, area-cheap arithmetic unit is acceptable.

---
 rtl/addsub_seq_if.sv | 28 ++
 rtl/addsub_seq.sv | 159 +++++++++++++++
 tb/tb_addsub_seq.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/addsub_seq_if.sv
// Operand/result bus for addsub_seq.
//   master drives: start, mode, a, b, cin
//   slave drives : busy, done, result, cout, overflow, zero
interface addsub_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, mode, a, b, cin,
        input  busy, done, result, cout, overflow, zero
    );

    modport slave (
        input  start, mode, a, b, cin,
        output busy, done, result, cout, overflow, zero
    );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle adder/subtractor: a WIDTH-bit A + B (+cin) or A + ~B (+cin),
// computed CHUNK bits per clock through a ripple full-adder slice.
// Ports:
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - addsub_seq_if.slave: start/mode/a/b/cin in;
//           busy/done/result/cout/overflow/zero out (all registered)
module addsub_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    addsub_seq_if.slave  bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             w_accept;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    // Operands shift right each cycle so the live chunk is always at [CHUNK-1:0].
    // Subtract mode is folded into r_opb at acceptance.
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;

    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_overflow;
    logic             r_zero;

    logic [CHUNK-1:0] w_sum;
    logic             w_c_out;
    logic             w_c_msb;
    logic [WIDTH-1:0] w_acc_nxt;
    logic             w_last;

    // Ripple slice; w_c_msb is the carry into the top bit of the chunk,
    // which on the final chunk is the carry into the result MSB.
    always_comb begin : p_slice
        logic v_c;
        v_c     = r_carry;
        w_sum   = '0;
        w_c_msb = r_carry;
        for (int i = 0; i < int'(CHUNK); i++) begin
            if (i == int'(CHUNK) - 1) begin
                w_c_msb = v_c;
            end
            w_sum[i] = r_opa[i] ^ r_opb[i] ^ v_c;
            v_c      = (r_opa[i] & r_opb[i]) | (v_c & (r_opa[i] ^ r_opb[i]));
        end
        w_c_out = v_c;
    end

    // New chunk enters at the top; after NCHUNK shifts the accumulator is aligned.
    assign w_acc_nxt = WIDTH'({w_sum, r_acc} >> CHUNK);
    assign w_last    = (r_cnt == CNT_W'(NCHUNK - 1));

    // State register and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next     = S_RUN;
                    w_accept   = 1'b1;
                    w_busy_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next     = S_DONE;
                    w_done_nxt = 1'b1;
                end else begin
                    w_busy_nxt = 1'b1;
                end
            end
            S_DONE: begin
                if (bus.start) begin
                    w_next     = S_RUN;
                    w_accept   = 1'b1;
                    w_busy_nxt = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, chunk iteration, result/flag load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa      <= '0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_carry    <= 1'b0;
            r_cnt      <= '0;
            r_result   <= '0;
            r_cout     <= 1'b0;
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            r_opa   <= bus.a;
            r_opb   <= bus.mode ? ~bus.b : bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_opa   <= r_opa >> CHUNK;
            r_opb   <= r_opb >> CHUNK;
            r_acc   <= w_acc_nxt;
            r_carry <= w_c_out;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_result   <= w_acc_nxt;
                r_cout     <= w_c_out;
                r_overflow <= w_c_msb ^ w_c_out;
                r_zero     <= (w_acc_nxt == '0);
            end
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.result   = r_result;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_overflow;
    assign bus.zero     = r_zero;
endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq (WIDTH=8, CHUNK=2): directed cases
// plus random operations, scoreboard queue checked by a done monitor.
module tb_addsub_seq;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned CHUNK  = 2;
    localparam int unsigned NCHUNK = WIDTH / CHUNK;

    typedef struct {
        logic [7:0] res;
        logic       cout;
        logic       ovf;
        logic       zero;
        int         cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    logic [7:0] last_res  = '0;
    logic       last_cout = 1'b0;
    logic       last_ovf  = 1'b0;
    logic       last_zero = 1'b0;

    addsub_seq_if #(.WIDTH(WIDTH)) bus ();

    addsub_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic mode, input logic cin, input int dcyc);
        exp_t       e;
        logic [7:0] bv;
        int         u;
        int         s;
        bv     = mode ? ~b : b;
        u      = int'(a) + int'(bv) + int'(cin);
        s      = int'($signed(a)) + int'($signed(bv)) + int'(cin);
        e.res  = 8'(u);
        e.cout = (u >= 256);
        e.ovf  = (s > 127) || (s < -128);
        e.zero = (8'(u) == 8'h00);
        e.cyc  = dcyc;
        return e;
    endfunction

    // Called at a negedge; request is accepted on the following rising edge.
    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic mode, input logic cin);
        bus.a     = a;
        bus.b     = b;
        bus.mode  = mode;
        bus.cin   = cin;
        bus.start = 1'b1;
        sb.push_back(model(a, b, mode, cin, cyc + 1 + int'(NCHUNK)));
    endtask

    // Returns at the negedge where busy has dropped (the DONE cycle).
    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("busy_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b,
                         input logic mode, input logic cin);
        drive(a, b, mode, cin);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: compare on done, otherwise outputs must hold their last values.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.done) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_done", 32'(bus.done), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", 32'(cyc), 32'(e.cyc));
                        chk("result", 32'(bus.result), 32'(e.res));
                        chk("cout", 32'(bus.cout), 32'(e.cout));
                        chk("overflow", 32'(bus.overflow), 32'(e.ovf));
                        chk("zero", 32'(bus.zero), 32'(e.zero));
                        chk("busy_in_done", 32'(bus.busy), 32'd0);
                        last_res  = e.res;
                        last_cout = e.cout;
                        last_ovf  = e.ovf;
                        last_zero = e.zero;
                    end
                end else begin
                    chk("hold_result", 32'(bus.result), 32'(last_res));
                    chk("hold_flags", {29'd0, bus.cout, bus.overflow, bus.zero},
                        {29'd0, last_cout, last_ovf, last_zero});
                end
            end
        end
    end

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"}, 32'(bus.busy), 32'd0);
        chk({nm, "_done"}, 32'(bus.done), 32'd0);
        chk({nm, "_result"}, 32'(bus.result), 32'd0);
        chk({nm, "_cout"}, 32'(bus.cout), 32'd0);
        chk({nm, "_overflow"}, 32'(bus.overflow), 32'd0);
        chk({nm, "_zero"}, 32'(bus.zero), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.mode  = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");

        // First add, immediately after reset release, with busy/done timing
        rst_n = 1'b1;
        drive(8'h35, 8'h4A, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_c1", 32'(bus.busy), 32'd1);
        for (int k = 0; k < int'(NCHUNK) - 1; k++) begin
            @(negedge clk);
            chk("busy_run", 32'(bus.busy), 32'd1);
            chk("done_early", 32'(bus.done), 32'd0);
        end
        @(negedge clk);
        chk("busy_end", 32'(bus.busy), 32'd0);
        chk("done_pulse", 32'(bus.done), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(bus.done), 32'd0);
        drain();

        // Directed arithmetic corners
        issue(8'h50, 8'h30, 1'b1, 1'b1);
        issue(8'h30, 8'h50, 1'b1, 1'b1);
        issue(8'h7F, 8'h01, 1'b0, 1'b0);
        issue(8'h80, 8'h01, 1'b1, 1'b1);
        issue(8'h5A, 8'h5A, 1'b1, 1'b1);
        drain();

        // Operand changes and a start pulse during RUN are ignored
        drive(8'h35, 8'h4A, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        bus.mode  = 1'b1;
        bus.cin   = 1'b1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        drain();

        // Start held high; second op presented in the DONE cycle
        drive(8'h50, 8'h30, 1'b1, 1'b1);
        @(negedge clk);
        wait_idle();
        drive(8'h30, 8'h50, 1'b1, 1'b1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        drain();

        // Reset in the second RUN cycle aborts the operation
        drive(8'h12, 8'h34, 1'b0, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        last_res  = '0;
        last_cout = 1'b0;
        last_ovf  = 1'b0;
        last_zero = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(8'h01, 8'h01, 1'b0, 1'b0);
        drain();

        // Random operations, mixing back-to-back and gapped issue
        for (int n = 0; n < 40; n++) begin
            issue(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
